// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake.
// Single-cycle ops complete on the accept edge. Shifts iterate one bit per
// clock. The optional shift-add multiplier takes DATAPATH_WIDTH steps.
// Optional feature macro: ALU_SEQ_MUL_EN (enables opcode 11, iterative MUL).
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start_in     - issue request, sampled only in IDLE
//   alu_ctrl_in  - opcode, a_in / b_in operands, shamt_in shift distance
//   accum_out    - registered result of the last completed op
//   zero_out     - combinational (accum_out == 0)
//   busy_out     - high while a multi-cycle op is in flight
//   done_out     - one-cycle completion pulse, aligned with accum_out update
module alu_seq #(
  parameter int unsigned DATAPATH_WIDTH = 64,
  parameter int unsigned SHAMT_WIDTH    = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_in,
  input  logic [3:0]                alu_ctrl_in,
  input  logic [DATAPATH_WIDTH-1:0] a_in,
  input  logic [DATAPATH_WIDTH-1:0] b_in,
  input  logic [SHAMT_WIDTH-1:0]    shamt_in,
  output logic [DATAPATH_WIDTH-1:0] accum_out,
  output logic                      zero_out,
  output logic                      busy_out,
  output logic                      done_out
);

  localparam int unsigned W     = DATAPATH_WIDTH;
  // One extra bit so the multiplier count of W fits.
  localparam int unsigned CNT_W = SHAMT_WIDTH + 1;

  localparam logic [3:0] OP_CONST = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_LT    = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd11;
`endif

  // Repeating 'hdeafdeaf pattern truncated to W bits.
  function automatic logic [W-1:0] deaf_pattern();
    logic [31:0]  p;
    logic [W-1:0] r;
    p = 32'hdeafdeaf;
    r = '0;
    for (int i = 0; i < int'(W); i++) r[i] = p[5'(i)];
    return r;
  endfunction

  localparam logic [W-1:0] DEAF_CONST = deaf_pattern();

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [W-1:0]     work_q, work_d;       // shift operand, or multiplicand
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     accum_d;
  logic             done_d;
  logic [W-1:0]     alu_c;
  logic [W-1:0]     shift_c;
`ifdef ALU_SEQ_MUL_EN
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     psum_q, psum_d;
  logic [W-1:0]     psum_c;
`endif

  // Single-cycle result; shift/mul/undefined opcodes give 0 here.
  always_comb begin
    alu_c = '0;
    case (alu_ctrl_in)
      OP_CONST: alu_c = DEAF_CONST;
      OP_ADD:   alu_c = a_in + b_in;
      OP_SUB:   alu_c = a_in - b_in;
      OP_AND:   alu_c = a_in & b_in;
      OP_OR:    alu_c = a_in | b_in;
      OP_NOT:   alu_c = ~a_in;
      OP_XOR:   alu_c = a_in ^ b_in;
      OP_LT:    alu_c = W'(a_in < b_in);
      default:  alu_c = '0;
    endcase
  end

  // One-bit step of the in-flight shift.
  always_comb begin
    case (op_q)
      OP_SLL:  shift_c = work_q << 1;
      OP_SRL:  shift_c = work_q >> 1;
      default: shift_c = {work_q[W-1], work_q[W-1:1]};
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Partial sum after the current multiplier bit.
  assign psum_c = mplier_q[0] ? (psum_q + work_q) : psum_q;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    accum_d = accum_out;
    done_d  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mplier_d = mplier_q;
    psum_d   = psum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          op_d = alu_ctrl_in;
          case (alu_ctrl_in)
            OP_SLL, OP_SRL, OP_SRA: begin
              if (shamt_in == '0) begin
                accum_d = a_in;
                done_d  = 1'b1;
              end else begin
                work_d  = a_in;
                cnt_d   = CNT_W'(shamt_in);
                state_d = S_SHIFT;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              work_d   = a_in;
              mplier_d = b_in;
              psum_d   = '0;
              cnt_d    = CNT_W'(W);
              state_d  = S_MUL;
            end
`endif
            default: begin
              accum_d = alu_c;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        work_d = shift_c;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          accum_d = shift_c;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        psum_d   = psum_c;
        work_d   = work_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          accum_d = psum_c;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any op without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      accum_out <= '0;
      done_out  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mplier_q  <= '0;
      psum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      accum_out <= accum_d;
      done_out  <= done_d;
`ifdef ALU_SEQ_MUL_EN
      mplier_q  <= mplier_d;
      psum_q    <= psum_d;
`endif
    end
  end

  assign busy_out = (state_q != S_IDLE);
  assign zero_out = (accum_out == '0);

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the Arya core datapath. It adds the following over the single-cycle ALU:
- variable-distance shifts (SLL/SRL/SRA) by 0..DATAPATH_WIDTH-1 bits, iterated one bit per clock;
- an optional iterative shift-add multiplier;
- a start/busy/done handshake.

The execute stage issues one operation, stalls on `busy_out`, and captures the registered result on `done_out`.

## Interface
- `DATAPATH_WIDTH`, 64 — operand/result width; must be a power of two, at least 8.
- `SHAMT_WIDTH`, 6 — shift-amount width; equals log2(DATAPATH_WIDTH).
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — reset, synchronous, active-low.
- `start_in` input 1 — issue request; sampled only when the block is idle.
- `alu_ctrl_in` input 4 — opcode, sampled at accept.
- `a_in` input DATAPATH_WIDTH — operand A, sampled at accept.
- `b_in` input DATAPATH_WIDTH — operand B, sampled at accept.
- `shamt_in` input SHAMT_WIDTH — shift distance, sampled at accept; used only by opcodes 8/9/10.
- `accum_out` output DATAPATH_WIDTH — registered result; holds the last completed result.
- `zero_out` output 1 — combinational, `(accum_out == 0)`.
- `busy_out` output 1 — high while a multi-cycle operation is in progress.
- `done_out` output 1 — one-cycle pulse; `accum_out` is updated on the same edge.

## Operation
- **Opcodes.** All wrap modulo 2^DATAPATH_WIDTH; results are truncated or zero-extended to DATAPATH_WIDTH.
  - 0: constant, `'hdeafdeaf…` truncated to DATAPATH_WIDTH.
  - 1: A+B.
  - 2: A−B.
  - 3: A&B.
  - 4: A|B.
  - 5: ~A.
  - 6: A^B.
  - 7: unsigned A<B, zero-extended to 1/0.
  - 8: SLL A by shamt.
  - 9: SRL A by shamt (zero fill).
  - 10: SRA A by shamt (fills with A[MSB]).
  - 11: MUL, low DATAPATH_WIDTH bits of A×B, unsigned (only when `ALU_SEQ_MUL_EN` is defined).
  - 12–15 and undefined ops: result 0, single-cycle.
- **FSM states.** IDLE, SHIFT, MUL.
- **Accept.** `start_in`=1 in IDLE; latches opcode, A, B and shamt.
- **Single-cycle ops.** These are opcodes 0–7, shifts with shamt=0, and default ops. The accept edge writes `accum_out` and asserts `done_out`; the FSM stays in IDLE.
- **Shift, shamt=n>0.**
  - The accept edge loads the working register from A and the counter from n, and enters SHIFT.
  - Each SHIFT edge shifts one bit and decrements the counter.
  - The edge that takes the counter 1→0 writes `accum_out`, pulses `done_out`, and returns to IDLE.
- **MUL.**
  - The accept edge loads multiplicand A, multiplier B, a zero partial sum and a counter of DATAPATH_WIDTH, and enters MUL.
  - Each MUL edge adds the multiplicand to the partial sum if the multiplier LSB is 1, shifts the multiplicand left by 1 and the multiplier right by 1, and decrements the counter.
  - The last step writes `accum_out`, pulses `done_out`, and returns to IDLE.
- **`busy_out`.** Equals (state != IDLE).
- **`start_in` while busy.** Ignored; it is not queued, and inputs may change freely while busy.
- **`accum_out` stability.** Unchanged except on a completion edge; no partial results are visible.

## Timing
- Latency L counts rising edges from the accept edge to the edge that raises `done_out`, the accept edge included:
  - single-cycle ops: L=1;
  - shifts: L=1+n;
  - MUL: L=1+DATAPATH_WIDTH.
- `busy_out` is high for exactly L−1 cycles, starting after the accept edge.
- **Back-to-back issue.** The block is in IDLE during the `done_out` cycle, so `start_in` in that cycle is accepted. Throughput is one op per L cycles.
- **Reset.** `rst_n`=0 at an edge forces IDLE, `accum_out`=0, `done_out`=0, `busy_out`=0, counters 0. `zero_out` is therefore 1.
- **Reset mid-operation.** Aborts the operation with no `done_out` pulse.
- **Reset with `start_in`.** Reset wins; the start is dropped.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - opcode 11 is the iterative multiplier described above;
  - the MUL state and its multiplicand, multiplier and partial-sum registers exist.
- `ALU_SEQ_MUL_EN` undefined:
  - no MUL state or registers are built;
  - opcode 11 behaves as a default op: single-cycle, result 0, `done_out` at L=1.

## Test plan
- **Reset, then idle.** Hold `rst_n`=0 for 2 edges, release → `accum_out`=0, `zero_out`=1, `busy_out`=0, `done_out`=0.
- **Back-to-back single-cycle ops.** ADD A=5, B=7, then SUB A=3, B=3 issued in the ADD's `done_out` cycle →
  - first `done_out` with `accum_out`=12;
  - next cycle `done_out` again with `accum_out`=0, `zero_out`=1.
- **SRA by 4.** SRA A=0x8000_0000_0000_0010, shamt=4 →
  - `busy_out` high 4 cycles;
  - `done_out` at L=5 with `accum_out`=0xF800_0000_0000_0001;
  - SLL with shamt=0 completes at L=1 with `accum_out`=A.
- **Start ignored while busy.** SLL A=1, shamt=63; pulse `start_in` with ADD at cycle 10 →
  - the ADD is ignored;
  - `done_out` at L=64 with `accum_out`=0x8000_0000_0000_0000.
- **MUL.** With `ALU_SEQ_MUL_EN`: A=0xFFFF_FFFF_FFFF_FFFF, B=3 → `done_out` at L=65, `accum_out`=0xFFFF_FFFF_FFFF_FFFD. Without the macro: `accum_out`=0 at L=1.
- **Reset mid-MUL.** Assert `rst_n`=0 at step 20 of a MUL → no `done_out`; `accum_out`=0; the next ADD A=1, B=1 completes normally with 2.
